// File: rtl/bit_serializer_pkg.sv
// Shared state encodings and shift helper for the bit_serializer parallel-to-serial stage.
package bit_serializer_pkg;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    // Widest word the shift helper supports; callers truncate back to their own width.
    localparam int unsigned MaxWidth = 64;

    typedef logic [MaxWidth-1:0] shift_word_t;

    // Left shift keeps the low bits valid for MSB-first, right shift (zero-extended) for LSB-first.
    function automatic shift_word_t next_shift(input shift_word_t r, input logic msb_first);
        return msb_first ? (r << 1) : (r >> 1);
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding register with full flag, parks a word accepted while the shifter is busy.
module piso_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wr_i) begin
            full_d = 1'b1;
            data_d = wdata_i;
        end else if (rd_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign rdata_o = data_q;
    assign full_o  = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the 1010 detector; one bit per clock, all outputs registered.
// Define SERIALIZER_PREFETCH_EN to add a one-entry holding register for gapless back-to-back words.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             load_now;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] shifted;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign accept  = load_valid & load_ready;
    assign shifted = WIDTH'(next_shift(shift_word_t'(shreg_q), MSB_FIRST));

`ifdef SERIALIZER_PREFETCH_EN
    logic             last_bit;
    logic             hold_wr, hold_rd, hold_full;
    logic [WIDTH-1:0] hold_data;

    assign last_bit = (state_q == S_SHIFT) && (cnt_q == '0);
    // Mid-word accepts park in the hold reg; IDLE and last-bit accepts bypass it.
    assign hold_wr   = accept && (state_q == S_SHIFT) && (cnt_q != '0);
    assign hold_rd   = last_bit && hold_full;
    assign load_now  = (accept && (state_q == S_IDLE)) || (last_bit && (hold_full || accept));
    assign load_word = hold_full ? hold_data : din;

    piso_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk_i   (clk),
        .reset_i (reset),
        .wr_i    (hold_wr),
        .wdata_i (din),
        .rd_i    (hold_rd),
        .rdata_o (hold_data),
        .full_o  (hold_full)
    );

    assign load_ready = ~hold_full;
`else
    logic load_ready_q;

    assign load_now  = accept;
    assign load_word = din;

    always_ff @(posedge clk) begin
        if (reset) begin
            load_ready_q <= 1'b1;
        end else begin
            load_ready_q <= (state_d == S_IDLE);
        end
    end

    assign load_ready = load_ready_q;
`endif

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        if (load_now) begin
            state_d      = S_SHIFT;
            shreg_d      = load_word;
            cnt_d        = CntLast;
            sout_d       = first_bit(load_word);
            sout_valid_d = 1'b1;
            busy_d       = 1'b1;
        end else if (state_q == S_SHIFT) begin
            if (cnt_q == '0) begin
                state_d      = S_IDLE;
                sout_d       = IDLE_LEVEL;
                sout_valid_d = 1'b0;
                busy_d       = 1'b0;
            end else begin
                shreg_d = shifted;
                cnt_d   = cnt_q - CntW'(1);
                sout_d  = first_bit(shifted);
                done_d  = (cnt_q == CntW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= IDLE_LEVEL;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first serializers side by side, per-cycle expected stream.
module tb_bit_serializer;

    typedef struct packed {
        logic v;
        logic m;
        logic l;
        logic d;
    } exp_t;

    typedef struct packed {
        logic [7:0] din;
        logic [7:0] mseq;  // MSB-first bit order, first-sent bit at [7]
        logic [7:0] lseq;  // LSB-first bit order, first-sent bit at [7]
    } vec_t;

    localparam exp_t IdleExp = '{v: 1'b0, m: 1'b0, l: 1'b1, d: 1'b0};

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       load_valid;
    logic       m_ready, m_sout, m_valid, m_busy, m_done;
    logic       l_ready, l_sout, l_valid, l_busy, l_done;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] got, want;
    logic [3:0] hist;
    int         det_hits;
    bit         mon_en = 1'b0;
    int         n_pass = 0;
    int         n_total = 0;
    vec_t       vecs[6];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .sout       (m_sout),
        .sout_valid (m_valid),
        .busy       (m_busy),
        .done       (m_done)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .sout       (l_sout),
        .sout_valid (l_valid),
        .busy       (l_busy),
        .done       (l_done)
    );

    task automatic check(input string name, input logic [7:0] g, input logic [7:0] w);
        n_total++;
        if (g === w) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, g, w, $time);
    endtask

    task automatic push_word(input logic [7:0] mseq, input logic [7:0] lseq);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{v: 1'b1, m: mseq[7-i], l: lseq[7-i], d: (i == 7)});
        end
    endtask

    task automatic send(input vec_t v);
        @(negedge clk);
        din        = v.din;
        load_valid = 1'b1;
        @(posedge clk);
        push_word(v.mseq, v.lseq);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 8'(exp_q.size()), 8'd0);
        @(negedge clk);
    endtask

    // Per-cycle stream check plus a behavioural 1010 detector on the MSB-first output.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = IdleExp;
            got  = {m_valid, m_sout, l_valid, l_sout, m_done, l_done, m_busy, l_busy};
            want = {e.v, e.m, e.v, e.l, e.d, e.d, e.v, e.v};
            check("stream", got, want);
`ifndef SERIALIZER_PREFETCH_EN
            check("ready", {6'd0, m_ready, l_ready}, {6'd0, ~e.v, ~e.v});
`endif
            if (reset) begin
                hist     = '0;
                det_hits = 0;
            end else if (m_valid) begin
                hist = {hist[2:0], m_sout};
                if (hist == 4'b1010) det_hits++;
            end
        end
    end

    initial begin
        vecs[0] = '{din: 8'hA0, mseq: 8'b1010_0000, lseq: 8'b0000_0101};
        vecs[1] = '{din: 8'h05, mseq: 8'b0000_0101, lseq: 8'b1010_0000};
        vecs[2] = '{din: 8'hFF, mseq: 8'b1111_1111, lseq: 8'b1111_1111};
        vecs[3] = '{din: 8'h01, mseq: 8'b0000_0001, lseq: 8'b1000_0000};
        vecs[4] = '{din: 8'h3C, mseq: 8'b0011_1100, lseq: 8'b0011_1100};
        vecs[5] = '{din: 8'hC5, mseq: 8'b1100_0101, lseq: 8'b1010_0011};

        reset      = 1'b1;
        load_valid = 1'b0;
        din        = 8'h00;
        hist       = '0;
        det_hits   = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {6'd0, m_ready, l_ready}, 8'b0000_0011);
        check("rst_outs", {m_sout, m_valid, m_busy, m_done, l_sout, l_valid, l_busy, l_done},
              8'b0000_1000);
        mon_en = 1'b1;
        reset  = 1'b0;

        // Long idle after reset: monitor expects constant idle level, detector stays quiet.
        repeat (20) @(negedge clk);
        check("idle_det", 8'(det_hits), 8'd0);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i]);
            drain();
            if (i == 0) check("det_once", 8'(det_hits), 8'd1);
        end

        // load_valid held through a busy word; second word must be taken exactly once.
        @(negedge clk);
        din        = 8'hA0;
        load_valid = 1'b1;
        @(posedge clk);
        push_word(vecs[0].mseq, vecs[0].lseq);
`ifndef SERIALIZER_PREFETCH_EN
        exp_q.push_back(IdleExp);
`endif
        push_word(vecs[4].mseq, vecs[4].lseq);
        @(negedge clk);
        din = 8'h3C;
        repeat (4) @(negedge clk);
        check("busy_ready", {6'd0, m_ready, l_ready}, 8'd0);
`ifdef SERIALIZER_PREFETCH_EN
        repeat (4) @(negedge clk);
`else
        repeat (5) @(negedge clk);
`endif
        load_valid = 1'b0;
        drain();

        // Reset during bit 3 of 8'hFF aborts the word with no done pulse.
        @(negedge clk);
        din        = 8'hFF;
        load_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) exp_q.push_back('{v: 1'b1, m: 1'b1, l: 1'b1, d: 1'b0});
        @(negedge clk);
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", {6'd0, m_ready, l_ready}, 8'b0000_0011);
        check("abort_outs", {m_sout, m_valid, m_busy, m_done, l_sout, l_valid, l_busy, l_done},
              8'b0000_1000);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Reset and load_valid on the same edge: no accept; the next offer is sent in full.
        reset      = 1'b1;
        din        = 8'h96;
        load_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        push_word(8'b1001_0110, 8'b0110_1001);
        @(negedge clk);
        load_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
